// File: rtl/noc_output_arbiter_pkg.sv
// Shared types and constants for the router output-port arbiter.
package noc_output_arbiter_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned FLIT_W = 35;
    localparam int unsigned TYPE_W = 3;

    // Flit type codes carried in the top TYPE_W bits of every flit.
    typedef enum logic [2:0] {
        BODY   = 3'b100,
        TAIL   = 3'b101,
        HEAD   = 3'b110,
        SINGLE = 3'b111
    } flit_type_t;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        REL,
        HOLD
    } arb_state_t;

    // Unknown codes behave like a single-flit packet so a bad header can never lock the port.
    function automatic flit_type_t decode_type(input logic [2:0] code);
        case (code)
            3'b110:  return HEAD;
            3'b100:  return BODY;
            3'b101:  return TAIL;
            default: return SINGLE;
        endcase
    endfunction

    // True when the flit closes its packet and the lock may be released.
    function automatic logic ends_packet(input flit_type_t t);
        return (t == TAIL) || (t == SINGLE);
    endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_select.sv
// Round-robin requester search: first asserted request at or after ptr, cyclically.
module rr_select #(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned PW     = 3
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NPORTS-1:0] onehot,
    output logic [PW-1:0]     idx,
    output logic              valid
);

    // Cyclic priority scan starting at ptr; the first hit wins.
    always_comb begin
        int unsigned pos;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        pos    = 0;
        for (int unsigned off = 0; off < NPORTS; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= NPORTS) begin
                pos = pos - NPORTS;
            end
            if (!valid && req[pos]) begin
                valid       = 1'b1;
                idx         = PW'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Output-port arbiter: round-robin with packet locking, bridging the granted
// input's 4-phase req/ack handshake onto the output handshake.
module noc_output_arbiter #(
    parameter int unsigned NPORTS = noc_output_arbiter_pkg::NPORTS,
    parameter int unsigned FLIT_W = noc_output_arbiter_pkg::FLIT_W,
    parameter int unsigned TYPE_W = noc_output_arbiter_pkg::TYPE_W
) (
    input  logic                     clk,
    input  logic                     preset,
    input  logic [NPORTS-1:0]        in_req,
    input  logic [NPORTS*FLIT_W-1:0] in_data,
    output logic [NPORTS-1:0]        in_ack,
    output logic                     out_req,
    output logic [FLIT_W-1:0]        out_data,
    input  logic                     out_ack,
    output logic [NPORTS-1:0]        grant,
    output logic                     busy
);
    import noc_output_arbiter_pkg::*;

    localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     sel_q, sel_d;
    flit_type_t        ftype_q, ftype_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [NPORTS-1:0] in_ack_q, in_ack_d;
    logic              out_req_q, out_req_d;
    logic [FLIT_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;

    logic [NPORTS-1:0] pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic [FLIT_W-1:0] pick_flit;
    logic [FLIT_W-1:0] held_flit;

    rr_select #(
        .NPORTS (NPORTS),
        .PW     (PW)
    ) u_rr_select (
        .req    (in_req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign pick_flit = in_data[pick_idx*FLIT_W +: FLIT_W];
    assign held_flit = in_data[sel_q*FLIT_W +: FLIT_W];

    assign in_ack   = in_ack_q;
    assign out_req  = out_req_q;
    assign out_data = out_data_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

    // State and output registers; reset drops the lock and every handshake level at once.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            ftype_q    <= SINGLE;
            grant_q    <= '0;
            in_ack_q   <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            ftype_q    <= ftype_d;
            grant_q    <= grant_d;
            in_ack_q   <= in_ack_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state sequencing through one flit transfer and the packet lock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick_valid) state_d = SEND;
            SEND: if (out_ack) state_d = REL;
            REL: begin
                if (!out_ack && !in_req[sel_q]) begin
                    state_d = ends_packet(ftype_q) ? IDLE : HOLD;
                end
            end
            HOLD: if (in_req[sel_q]) state_d = SEND;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, owner index and round-robin pointer.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        ftype_d    = ftype_q;
        grant_d    = grant_q;
        in_ack_d   = in_ack_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d      = pick_idx;
                    ftype_d    = decode_type(3'(pick_flit[FLIT_W-1 -: TYPE_W]));
                    grant_d    = pick_onehot;
                    out_data_d = pick_flit;
                    out_req_d  = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SEND: begin
                if (out_ack) begin
                    out_req_d = 1'b0;
                    in_ack_d  = grant_q;
                end
            end
            REL: begin
                if (!out_ack && !in_req[sel_q]) begin
                    in_ack_d = '0;
                    if (ends_packet(ftype_q)) begin
                        grant_d  = '0;
                        busy_d   = 1'b0;
                        rr_ptr_d = (sel_q == PW'(NPORTS - 1)) ? '0 : sel_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (in_req[sel_q]) begin
                    // A HEAD arriving inside a locked packet only continues it.
                    ftype_d    = decode_type(3'(held_flit[FLIT_W-1 -: TYPE_W]));
                    if (ftype_d == HEAD) ftype_d = BODY;
                    out_data_d = held_flit;
                    out_req_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
